// File: rtl/aq_spsram_2048x32_arb.sv
// Arbiter/sequencer sharing one single-port SRAM macro between a read (fetch) and a write (refill) requester.
// Latency: grants are combinational, rd_vld follows rd_gnt by one cycle; write priority with read starvation guard.
// Backpressure: requesters hold request and payload until granted; `define AQ_SPSRAM_INIT_EN adds a post-reset array clear.
module aq_spsram_2048x32_arb #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    input  logic                  rd_kill,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_wen_b,
    output logic                  wr_gnt,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]            starve_cnt;
    logic                  rd_vld_q;
    logic                  gnt_en;
    logic                  starved;
    logic                  init_act;
    logic [ADDR_WIDTH-1:0] init_addr;

`ifdef AQ_SPSRAM_INIT_EN
    typedef enum logic {INIT, DONE} init_state_t;
    init_state_t           state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  done_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= INIT;
            init_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            // init_done lags the DONE transition by one cycle
            done_q <= (state == DONE);
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (&init_cnt)
                    state <= DONE;
            end
        end
    end

    assign init_done = done_q;
    assign init_act  = cpurst_b & (state == INIT);
    assign init_addr = init_cnt;
`else
    assign init_done = 1'b1;
    assign init_act  = 1'b0;
    assign init_addr = '0;
`endif

    // Reset must drop grants combinationally, not just at the next edge.
    assign gnt_en  = init_done & cpurst_b;
    assign starved = rd_req & (starve_cnt == STARVE_LIM);
    assign wr_gnt  = wr_req & gnt_en & ~starved;
    assign rd_gnt  = rd_req & gnt_en & ~wr_gnt;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            starve_cnt <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            rd_vld_q <= rd_gnt;
            if (rd_gnt || !rd_req)
                starve_cnt <= '0;
            else if (wr_gnt && starve_cnt != 4'hF)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign rd_vld  = rd_vld_q & ~rd_kill;
    assign rd_data = sram_q;

    always_comb begin
        sram_a    = '0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_d    = '0;
        if (init_act) begin
            sram_a    = init_addr;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
        end else if (wr_gnt) begin
            sram_a    = wr_addr;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = wr_wen_b;
            sram_d    = wr_data;
        end else if (rd_gnt) begin
            sram_a    = rd_addr;
            sram_cen  = 1'b0;
        end
    end
endmodule

// File: tb/tb_aq_spsram_2048x32_arb.sv
// Bench for aq_spsram_2048x32_arb: behavioural SRAM macro plus a reference array and arbitration model.
`timescale 1ns/1ps
module tb_aq_spsram_2048x32_arb;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int SMAX = 4;
`ifdef AQ_SPSRAM_INIT_EN
    localparam logic INIT_RST = 1'b0;
`else
    localparam logic INIT_RST = 1'b1;
`endif

    logic          forever_cpuclk = 1'b0;
    logic          cpurst_b;
    logic          rd_req, rd_gnt, rd_kill, rd_vld;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_req, wr_gnt;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data, wr_wen_b;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, sram_q;

    logic [DW-1:0] macro_mem [0:2047];
    logic [DW-1:0] ref_mem   [0:2047];
    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [2*DW+AW+1:0] IDLE_PINS = {1'b1, 1'b1, {DW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}};

    always #5 forever_cpuclk = ~forever_cpuclk;

    aq_spsram_2048x32_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(SMAX)) dut (
        .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_kill(rd_kill),
        .rd_vld(rd_vld), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_wen_b(wr_wen_b),
        .wr_gnt(wr_gnt), .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    // Macro: bitwise active-low write mask, registered read data.
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                macro_mem[sram_a] <= (macro_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= macro_mem[sram_a];
        end
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [DW-1:0] wen);
        return (old & wen) | (d & ~wen);
    endfunction

    task automatic test_reset();
        cpurst_b = 1'b0; rd_kill = 1'b0;
        rd_req = 1'b1; rd_addr = 11'h010;
        wr_req = 1'b1; wr_addr = 11'h020; wr_data = '1; wr_wen_b = '0;
        repeat (3) @(negedge forever_cpuclk);
        #1;
        n_checks++; if ({wr_gnt, rd_gnt} !== 2'b00) $display("FAIL reset_gnt got %b want 00", {wr_gnt, rd_gnt}); else n_pass++;
        n_checks++; if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d} !== IDLE_PINS)
            $display("FAIL reset_pins got %h want %h", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, IDLE_PINS); else n_pass++;
        n_checks++; if (rd_vld !== 1'b0) $display("FAIL reset_vld got %b want 0", rd_vld); else n_pass++;
        n_checks++; if (init_done !== INIT_RST) $display("FAIL reset_init_done got %b want %b", init_done, INIT_RST); else n_pass++;
        rd_req = 1'b0; wr_req = 1'b0;
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
    endtask

`ifdef AQ_SPSRAM_INIT_EN
    task automatic test_init();
        logic [AW-1:0] exp_a;
        rd_req = 1'b1; rd_addr = 11'h5A5; wr_req = 1'b0; rd_kill = 1'b0;
        for (int c = 0; c < 2048; c++) begin
            exp_a = AW'(c);
            #1;
            n_checks++;
            if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d, rd_gnt, wr_gnt, init_done} !==
                {2'b00, {DW{1'b0}}, exp_a, {DW{1'b0}}, 3'b000})
                $display("FAIL init_write cycle %0d got a=%h cen=%b gwen=%b wen=%h d=%h gnt=%b%b done=%b want a=%h zero-write no grant",
                         c, sram_a, sram_cen, sram_gwen, sram_wen, sram_d, rd_gnt, wr_gnt, init_done, exp_a);
            else n_pass++;
            @(negedge forever_cpuclk);
        end
        #1;
        n_checks++; if ({init_done, rd_gnt, sram_cen} !== 3'b001)
            $display("FAIL init_gap got done/gnt/cen=%b want 001", {init_done, rd_gnt, sram_cen}); else n_pass++;
        @(negedge forever_cpuclk);
        #1;
        n_checks++; if ({init_done, rd_gnt, sram_a} !== {2'b11, 11'h5A5})
            $display("FAIL init_first_read got done=%b gnt=%b a=%h want 1 1 5a5", init_done, rd_gnt, sram_a); else n_pass++;
        @(negedge forever_cpuclk);
        rd_req = 1'b0;
        #1;
        n_checks++; if ({rd_vld, rd_data} !== {1'b1, 32'h0})
            $display("FAIL init_read_zero got vld=%b data=%h want 1 00000000", rd_vld, rd_data); else n_pass++;
        @(negedge forever_cpuclk);
        for (int k = 0; k < 2048; k++) ref_mem[k] = '0;
    endtask
`endif

    // Write then read back through the DUT, checking pins on both grants.
    task automatic test_rw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m, input bit do_read);
        wr_req = 1'b1; wr_addr = a; wr_data = d; wr_wen_b = m; rd_req = 1'b0;
        #1;
        n_checks++; if ({wr_gnt, rd_gnt} !== 2'b10) $display("FAIL rw_wr_gnt got %b want 10", {wr_gnt, rd_gnt}); else n_pass++;
        n_checks++; if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d} !== {2'b00, m, a, d})
            $display("FAIL rw_wr_pins got %h want %h", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, {2'b00, m, a, d}); else n_pass++;
        ref_mem[a] = merge(ref_mem[a], d, m);
        @(negedge forever_cpuclk);
        wr_req = 1'b0;
        if (do_read) begin
            rd_req = 1'b1; rd_addr = a;
            #1;
            n_checks++; if ({wr_gnt, rd_gnt} !== 2'b01) $display("FAIL rw_rd_gnt got %b want 01", {wr_gnt, rd_gnt}); else n_pass++;
            n_checks++; if ({sram_cen, sram_gwen, sram_a, sram_wen} !== {2'b01, a, {DW{1'b1}}})
                $display("FAIL rw_rd_pins got cen=%b gwen=%b a=%h wen=%h want 0 1 %h ffffffff", sram_cen, sram_gwen, sram_a, sram_wen, a); else n_pass++;
            @(negedge forever_cpuclk);
            rd_req = 1'b0;
            #1;
            n_checks++; if ({rd_vld, rd_data} !== {1'b1, ref_mem[a]})
                $display("FAIL rw_rd_data got vld=%b data=%h want 1 %h", rd_vld, rd_data, ref_mem[a]); else n_pass++;
            n_checks++; if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d} !== IDLE_PINS)
                $display("FAIL rw_idle_pins got %h want %h", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, IDLE_PINS); else n_pass++;
            @(negedge forever_cpuclk);
        end
    endtask

    task automatic test_single_read();
        test_rw(11'h010, 32'hDEADBEEF, '0, 1'b1);
        n_checks++; if (ref_mem[16] !== 32'hDEADBEEF) $display("FAIL single_read_model got %h want deadbeef", ref_mem[16]); else n_pass++;
    endtask

    task automatic test_masked_write();
        test_rw(11'h7FF, 32'h12345678, '0, 1'b0);
        test_rw(11'h7FF, 32'hFFFFFFFF, 32'hFFFF0000, 1'b1);
        n_checks++; if (macro_mem[2047] !== 32'h1234FFFF) $display("FAIL masked_array got %h want 1234ffff", macro_mem[2047]); else n_pass++;
    endtask

    task automatic test_starvation();
        logic exp_r, pend;
        logic [DW-1:0] pend_dat;
        pend = 1'b0; pend_dat = '0;
        rd_req = 1'b1; rd_addr = 11'h020; wr_req = 1'b1; wr_addr = 11'h020; wr_wen_b = '0;
        for (int i = 0; i < 2 * (SMAX + 1); i++) begin
            wr_data = $urandom;
            exp_r = ((i % (SMAX + 1)) == SMAX);
            #1;
            n_checks++; if ({wr_gnt, rd_gnt} !== {~exp_r, exp_r})
                $display("FAIL starve_gnt cycle %0d got wr/rd=%b want %b", i, {wr_gnt, rd_gnt}, {~exp_r, exp_r}); else n_pass++;
            n_checks++; if (rd_vld !== pend) $display("FAIL starve_vld cycle %0d got %b want %b", i, rd_vld, pend); else n_pass++;
            if (pend) begin
                n_checks++; if (rd_data !== pend_dat) $display("FAIL starve_data cycle %0d got %h want %h", i, rd_data, pend_dat); else n_pass++;
            end
            pend = exp_r;
            pend_dat = ref_mem[11'h020];
            if (!exp_r) ref_mem[11'h020] = merge(ref_mem[11'h020], wr_data, wr_wen_b);
            @(negedge forever_cpuclk);
        end
        rd_req = 1'b0; wr_req = 1'b0;
        #1;
        n_checks++; if ({rd_vld, rd_data} !== {1'b1, pend_dat})
            $display("FAIL starve_last_data got vld=%b data=%h want 1 %h", rd_vld, rd_data, pend_dat); else n_pass++;
        @(negedge forever_cpuclk);
    endtask

    task automatic test_kill();
        rd_req = 1'b1; rd_addr = 11'h010; wr_req = 1'b0; rd_kill = 1'b0;
        #1;
        n_checks++; if (rd_gnt !== 1'b1) $display("FAIL kill_first_gnt got %b want 1", rd_gnt); else n_pass++;
        @(negedge forever_cpuclk);
        rd_addr = 11'h7FF; rd_kill = 1'b1;
        #1;
        n_checks++; if ({rd_vld, rd_gnt} !== 2'b01) $display("FAIL kill_vld got vld/gnt=%b want 01", {rd_vld, rd_gnt}); else n_pass++;
        @(negedge forever_cpuclk);
        rd_req = 1'b0; rd_kill = 1'b0;
        #1;
        n_checks++; if ({rd_vld, rd_data} !== {1'b1, ref_mem[11'h7FF]})
            $display("FAIL kill_next_data got vld=%b data=%h want 1 %h", rd_vld, rd_data, ref_mem[11'h7FF]); else n_pass++;
        @(negedge forever_cpuclk);
    endtask

    task automatic test_random();
        logic rp, wp, exp_w, exp_r, pend, exp_vld;
        logic [DW-1:0] pend_dat;
        int waits;
        rp = 1'b0; wp = 1'b0; pend = 1'b0; pend_dat = '0; waits = 0;
        for (int k = 0; k < 8; k++) test_rw(AW'(11'h300 + k), $urandom, '0, 1'b0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!rp && ($urandom % 3 == 0)) begin rp = 1'b1; rd_addr = AW'(11'h300 + $urandom % 8); end
            if (!wp && ($urandom % 2 == 0)) begin
                wp = 1'b1; wr_addr = AW'(11'h300 + $urandom % 8); wr_data = $urandom;
                wr_wen_b = ($urandom % 3 == 0) ? '0 : $urandom;
            end
            rd_req = rp; wr_req = wp; rd_kill = ($urandom % 4 == 0);
            exp_w = wp && !(rp && waits == SMAX);
            exp_r = rp && !exp_w;
            exp_vld = pend && !rd_kill;
            #1;
            n_checks++; if ({wr_gnt, rd_gnt} !== {exp_w, exp_r})
                $display("FAIL rand_gnt cycle %0d got wr/rd=%b want %b", cyc, {wr_gnt, rd_gnt}, {exp_w, exp_r}); else n_pass++;
            n_checks++;
            if (exp_w) begin
                if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d} !== {2'b00, wr_wen_b, wr_addr, wr_data})
                    $display("FAIL rand_wr_pins cycle %0d got %h", cyc, {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}); else n_pass++;
            end else if (exp_r) begin
                if ({sram_cen, sram_gwen, sram_wen, sram_a} !== {2'b01, {DW{1'b1}}, rd_addr})
                    $display("FAIL rand_rd_pins cycle %0d got cen=%b gwen=%b a=%h want a=%h", cyc, sram_cen, sram_gwen, sram_a, rd_addr); else n_pass++;
            end else begin
                if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d} !== IDLE_PINS)
                    $display("FAIL rand_idle_pins cycle %0d got %h", cyc, {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}); else n_pass++;
            end
            n_checks++; if (rd_vld !== exp_vld) $display("FAIL rand_vld cycle %0d got %b want %b", cyc, rd_vld, exp_vld); else n_pass++;
            if (exp_vld) begin
                n_checks++; if (rd_data !== pend_dat) $display("FAIL rand_data cycle %0d got %h want %h", cyc, rd_data, pend_dat); else n_pass++;
            end
            pend = exp_r;
            pend_dat = ref_mem[rd_addr];
            if (exp_w) begin ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_wen_b); wp = 1'b0; end
            if (exp_r || !rp) waits = 0;
            else if (exp_w && waits < 15) waits++;
            if (exp_r) rp = 1'b0;
            @(negedge forever_cpuclk);
        end
        rd_req = 1'b0; wr_req = 1'b0; rd_kill = 1'b0;
        #1;
        n_checks++; if (rd_vld !== pend) $display("FAIL rand_tail_vld got %b want %b", rd_vld, pend); else n_pass++;
        if (pend) begin
            n_checks++; if (rd_data !== pend_dat) $display("FAIL rand_tail_data got %h want %h", rd_data, pend_dat); else n_pass++;
        end
        @(negedge forever_cpuclk);
    endtask

    task automatic test_reset_mid();
        rd_req = 1'b1; rd_addr = 11'h010; wr_req = 1'b0; rd_kill = 1'b0;
        #1;
        n_checks++; if (rd_gnt !== 1'b1) $display("FAIL midrst_gnt got %b want 1", rd_gnt); else n_pass++;
        @(negedge forever_cpuclk);
        cpurst_b = 1'b0; wr_req = 1'b1; wr_addr = 11'h040; wr_data = 32'hA5A55A5A; wr_wen_b = '0;
        #1;
        n_checks++; if ({rd_vld, wr_gnt, rd_gnt, sram_cen} !== 4'b0001)
            $display("FAIL midrst_drop got vld/wg/rg/cen=%b want 0001", {rd_vld, wr_gnt, rd_gnt, sram_cen}); else n_pass++;
        n_checks++; if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d} !== IDLE_PINS)
            $display("FAIL midrst_pins got %h want %h", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d}, IDLE_PINS); else n_pass++;
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
`ifdef AQ_SPSRAM_INIT_EN
        wr_req = 1'b0;
        test_init();
`else
        #1;
        n_checks++; if ({rd_vld, wr_gnt, rd_gnt} !== 3'b010)
            $display("FAIL midrst_release got vld/wg/rg=%b want 010", {rd_vld, wr_gnt, rd_gnt}); else n_pass++;
        ref_mem[11'h040] = merge(ref_mem[11'h040], wr_data, wr_wen_b);
        @(negedge forever_cpuclk);
        wr_req = 1'b0;
        #1;
        n_checks++; if ({rd_vld, rd_gnt} !== 2'b01) $display("FAIL midrst_retry got vld/gnt=%b want 01", {rd_vld, rd_gnt}); else n_pass++;
        @(negedge forever_cpuclk);
        rd_req = 1'b0;
        #1;
        n_checks++; if ({rd_vld, rd_data} !== {1'b1, ref_mem[11'h010]})
            $display("FAIL midrst_data got vld=%b data=%h want 1 %h", rd_vld, rd_data, ref_mem[11'h010]); else n_pass++;
        @(negedge forever_cpuclk);
`endif
    endtask

    initial begin
        for (int k = 0; k < 2048; k++) ref_mem[k] = '0;
        test_reset();
`ifdef AQ_SPSRAM_INIT_EN
        test_init();
`endif
        test_single_read();
        test_masked_write();
        test_starvation();
        test_kill();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
